udp_tx_framer: RTL and testbench

//  Parametrised UDP/IPv4/Ethernet frame builder. Successor to the fixed-size TX engine.
//  Per packet: accepts a descriptor (length, destination MAC/IP/port), then a byte payload

---
 rtl/udp_tx_framer_pkg.sv | 30 +++
 rtl/udp_tx_framer_ip_hdr_checksum.sv | 37 +++
 rtl/udp_tx_framer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_udp_tx_framer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_tx_framer_pkg.sv
// udp_tx_framer shared definitions.
// FSM states, header constants and checksum fold helper.
package udp_tx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HDR,
    ST_PAY,
    ST_PAD,
    ST_END
  } state_e;

  localparam int unsigned HDR_LEN   = 42;
  localparam int unsigned MIN_FRAME = 60;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;

  // Two end-around carry folds of a 20-bit partial sum.
  function automatic logic [15:0] csum_fold(input logic [19:0] s);
    logic [16:0] f1;
    logic [15:0] f2;
    f1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    f2 = f1[15:0] + {15'd0, f1[16]};
    return f2;
  endfunction

endpackage

// File: rtl/udp_tx_framer_ip_hdr_checksum.sv
// IPv4 header checksum, 2-cycle pipeline.
// Stage 1 sums nine words, stage 2 folds and inverts.
module ip_hdr_checksum
  import udp_tx_framer_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [143:0] words,
  output logic [15:0]  csum
);

  logic [19:0] sum_d, sum_q;
  logic [15:0] csum_d, csum_q;

  // Wide sum of all words, then fold/invert of the registered sum.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + {4'd0, words[16*i +: 16]};
    end
    csum_d = ~csum_fold(sum_q);
  end

  // Pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      csum_q <= '0;
    end else begin
      sum_q  <= sum_d;
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;

endmodule

// File: rtl/udp_tx_framer.sv
// UDP/IPv4/Ethernet frame builder, 8-bit AXI-Stream out.
// Header, payload (zero-filled if short), pad to 60 B.
module udp_tx_framer
  import udp_tx_framer_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1472,
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_00,
  parameter logic [31:0] SRC_IP      = 32'hC0A8_0132,
  parameter logic [15:0] SRC_PORT    = 16'd50000,
  parameter logic [7:0]  TTL         = 8'h40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_len,
  input  logic [47:0] cmd_dst_mac,
  input  logic [31:0] cmd_dst_ip,
  input  logic [15:0] cmd_dst_port,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic        err_short,
  output logic        err_long
);

  localparam logic [15:0] MAX_LEN     = 16'(MAX_PAYLOAD);
  localparam logic [10:0] HDR_LEN_W   = 11'(HDR_LEN);
  localparam logic [10:0] MIN_FRAME_W = 11'(MIN_FRAME);
  localparam logic [15:0] PAD_LIMIT   = 16'(MIN_FRAME - HDR_LEN);

  state_e      state_d, state_q;
  logic [10:0] idx_d, idx_q;
  logic [15:0] rem_d, rem_q;
  logic [15:0] id_d, id_q;
  logic [15:0] len_d, len_q;
  logic [10:0] flen_d, flen_q;
  logic [47:0] mac_d, mac_q;
  logic [31:0] dip_d, dip_q;
  logic [15:0] dport_d, dport_q;
  logic        ccnt_d, ccnt_q;
  logic        zfill_d, zfill_q;
  logic        drain_d, drain_q;
  logic [7:0]  tdata_d, tdata_q;
  logic        tvalid_d, tvalid_q;
  logic        tlast_d, tlast_q;
  logic        eshort_d, eshort_q;
  logic        elong_d, elong_q;

  logic        load;
  logic        s_ready;
  logic        pay_done;
  logic        clamp;
  logic [15:0] l_new;
  logic [15:0] ip_len;
  logic [15:0] udp_len;
  logic [15:0] csum;
  logic [335:0] hdr;
  logic [7:0]  hdr_byte;

  assign load    = !tvalid_q || m_axis_tready;
  assign clamp   = cmd_len > MAX_LEN;
  assign l_new   = clamp ? MAX_LEN : cmd_len;
  assign ip_len  = len_q + 16'd28;
  assign udp_len = len_q + 16'd8;

  ip_hdr_checksum u_csum (
    .clk   (clk),
    .rst   (rst),
    .words ({{IP_VER_IHL, 8'h00}, ip_len, id_q, 16'h0000,
             {TTL, IP_PROTO_UDP}, SRC_IP[31:16], SRC_IP[15:0],
             dip_q[31:16], dip_q[15:0]}),
    .csum  (csum)
  );

  assign hdr = {mac_q, SRC_MAC, ETHERTYPE_IPV4,
                IP_VER_IHL, 8'h00, ip_len, id_q, 16'h0000,
                TTL, IP_PROTO_UDP, csum, SRC_IP, dip_q,
                SRC_PORT, dport_q, udp_len, 16'h0000};

  // Select the header byte at the current frame index.
  always_comb begin
    hdr_byte = 8'h00;
    for (int i = 0; i < 42; i++) begin
      if (idx_q[5:0] == 6'(i)) hdr_byte = hdr[335-8*i -: 8];
    end
  end

  // Frame sequencing, output byte load and payload handshake.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    id_d     = id_q;
    len_d    = len_q;
    flen_d   = flen_q;
    mac_d    = mac_q;
    dip_d    = dip_q;
    dport_d  = dport_q;
    ccnt_d   = ccnt_q;
    zfill_d  = zfill_q;
    drain_d  = drain_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    eshort_d = 1'b0;
    elong_d  = 1'b0;
    s_ready  = 1'b0;
    pay_done = 1'b0;

    if (load) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    if (drain_q) begin
      s_ready = 1'b1;
      if (s_axis_tvalid && s_axis_tlast) drain_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          len_d   = l_new;
          flen_d  = (l_new < PAD_LIMIT) ? MIN_FRAME_W
                                        : l_new[10:0] + HDR_LEN_W;
          mac_d   = cmd_dst_mac;
          dip_d   = cmd_dst_ip;
          dport_d = cmd_dst_port;
          elong_d = clamp;
          ccnt_d  = 1'b0;
          state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        ccnt_d = 1'b1;
        if (ccnt_q) begin
          idx_d   = '0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (load) begin
          tdata_d  = hdr_byte;
          tvalid_d = 1'b1;
          idx_d    = idx_q + 11'd1;
          if (idx_q == HDR_LEN_W - 11'd1) begin
            rem_d   = len_q;
            zfill_d = 1'b0;
            state_d = (len_q == 16'd0) ? ST_PAD : ST_PAY;
          end
        end
      end
      ST_PAY: begin
        if (zfill_q) begin
          if (load) begin
            tdata_d  = 8'h00;
            tvalid_d = 1'b1;
            idx_d    = idx_q + 11'd1;
            rem_d    = rem_q - 16'd1;
            pay_done = rem_q == 16'd1;
          end
        end else begin
          s_ready = load;
          if (load && s_axis_tvalid) begin
            tdata_d  = s_axis_tdata;
            tvalid_d = 1'b1;
            idx_d    = idx_q + 11'd1;
            rem_d    = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              pay_done = 1'b1;
              if (!s_axis_tlast) begin
                elong_d = 1'b1;
                drain_d = 1'b1;
              end
            end else if (s_axis_tlast) begin
              eshort_d = 1'b1;
              zfill_d  = 1'b1;
            end
          end
        end
        if (pay_done) begin
          zfill_d = 1'b0;
          if (idx_q == flen_q - 11'd1) begin
            tlast_d = 1'b1;
            state_d = ST_END;
          end else begin
            state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        if (load) begin
          tdata_d  = 8'h00;
          tvalid_d = 1'b1;
          idx_d    = idx_q + 11'd1;
          if (idx_q == flen_q - 11'd1) begin
            tlast_d = 1'b1;
            state_d = ST_END;
          end
        end
      end
      ST_END: begin
        if (load && !drain_q) begin
          id_d    = id_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      id_q     <= '0;
      len_q    <= '0;
      flen_q   <= '0;
      mac_q    <= '0;
      dip_q    <= '0;
      dport_q  <= '0;
      ccnt_q   <= 1'b0;
      zfill_q  <= 1'b0;
      drain_q  <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      eshort_q <= 1'b0;
      elong_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      id_q     <= id_d;
      len_q    <= len_d;
      flen_q   <= flen_d;
      mac_q    <= mac_d;
      dip_q    <= dip_d;
      dport_q  <= dport_d;
      ccnt_q   <= ccnt_d;
      zfill_q  <= zfill_d;
      drain_q  <= drain_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      eshort_q <= eshort_d;
      elong_q  <= elong_d;
    end
  end

  assign cmd_ready     = state_q == ST_IDLE;
  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign err_short     = eshort_q;
  assign err_long      = elong_q;

endmodule

// File: tb/tb_udp_tx_framer.sv
// udp_tx_framer bench: scoreboard of expected frame bytes,
// error-pulse counts, stall stability and reset behaviour.
module tb_udp_tx_framer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [47:0] cmd_dst_mac;
  logic [31:0] cmd_dst_ip;
  logic [15:0] cmd_dst_port;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        err_short;
  logic        err_long;

  udp_tx_framer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .cmd_dst_mac   (cmd_dst_mac),
    .cmd_dst_ip    (cmd_dst_ip),
    .cmd_dst_port  (cmd_dst_port),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .err_short     (err_short),
    .err_long      (err_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [47:0] MAC_A  = 48'hC8A3_62B2_D471;
  localparam logic [31:0] IP_A   = 32'hC0A8_0180;
  localparam logic [15:0] PORT_A = 16'd55555;

  int checks = 0;
  int errors = 0;

  logic [8:0]  sb[$];
  logic [15:0] exp_id = 16'd0;
  int          frames_done = 0;
  int          frame_bytes = 0;
  int          last_frame_len = 0;
  int          short_cnt = 0;
  int          long_cnt = 0;
  bit          stall_prev = 1'b0;
  logic [8:0]  held = '0;
  bit          tready_rand = 1'b0;
  logic [7:0]  cap[2048];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'((i * 13 + seed * 7 + 1) & 255);
  endfunction

  function automatic logic [15:0] ref_csum(input logic [15:0] iplen,
                                           input logic [15:0] id,
                                           input logic [31:0] dip);
    int unsigned s;
    logic [15:0] r;
    s = 32'h4500 + 32'(iplen) + 32'(id) + 32'h4011 + 32'hC0A8
      + 32'h0132 + 32'(dip[31:16]) + 32'(dip[15:0]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    r = s[15:0];
    return ~r;
  endfunction

  task automatic push_frame(input int len_req, input logic [47:0] mac,
                            input logic [31:0] ip, input logic [15:0] port,
                            input int nsent, input int seed,
                            output int flen);
    logic [7:0]  q[$];
    logic [15:0] iplen, udplen, cs;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [15:0] sport;
    int L;
    L      = (len_req > 1472) ? 1472 : len_req;
    iplen  = 16'(L + 28);
    udplen = 16'(L + 8);
    cs     = ref_csum(iplen, exp_id, ip);
    smac   = 48'h02_00_00_00_00_00;
    sip    = 32'hC0A8_0132;
    sport  = 16'd50000;
    for (int i = 5; i >= 0; i--) q.push_back(mac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(smac[8*i +: 8]);
    q.push_back(8'h08); q.push_back(8'h00);
    q.push_back(8'h45); q.push_back(8'h00);
    q.push_back(iplen[15:8]); q.push_back(iplen[7:0]);
    q.push_back(exp_id[15:8]); q.push_back(exp_id[7:0]);
    q.push_back(8'h00); q.push_back(8'h00);
    q.push_back(8'h40); q.push_back(8'h11);
    q.push_back(cs[15:8]); q.push_back(cs[7:0]);
    for (int i = 3; i >= 0; i--) q.push_back(sip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(ip[8*i +: 8]);
    q.push_back(sport[15:8]); q.push_back(sport[7:0]);
    q.push_back(port[15:8]); q.push_back(port[7:0]);
    q.push_back(udplen[15:8]); q.push_back(udplen[7:0]);
    q.push_back(8'h00); q.push_back(8'h00);
    for (int i = 0; i < L; i++) q.push_back((i < nsent) ? pat(seed, i) : 8'h00);
    while (q.size() < 60) q.push_back(8'h00);
    flen = q.size();
    for (int i = 0; i < flen; i++) sb.push_back({(i == flen - 1), q[i]});
  endtask

  // Output monitor: sampled 1 time unit before each rising edge.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      stall_prev  = 1'b0;
      frame_bytes = 0;
    end else begin
      if (err_short) short_cnt++;
      if (err_long) long_cnt++;
      if (stall_prev)
        check("stall_hold", 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
              32'({1'b1, held}));
      if (m_axis_tvalid && m_axis_tready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0)
          check("frame_byte", 32'({m_axis_tlast, m_axis_tdata}),
                32'(sb.pop_front()));
        if (frame_bytes < 2048) cap[frame_bytes] = m_axis_tdata;
        frame_bytes++;
        if (m_axis_tlast) begin
          last_frame_len = frame_bytes;
          frame_bytes    = 0;
          frames_done++;
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tlast, m_axis_tdata};
    end
  end

  // Sink backpressure.
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      m_axis_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic send_cmd(input int len, input logic [47:0] mac,
                          input logic [31:0] ip, input logic [15:0] port);
    bit hs;
    int n;
    @(negedge clk);
    cmd_len      = 16'(len);
    cmd_dst_mac  = mac;
    cmd_dst_ip   = ip;
    cmd_dst_port = port;
    cmd_valid    = 1'b1;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 2000) begin
      #4;
      hs = cmd_ready;
      @(posedge clk);
      n++;
      if (!hs) @(negedge clk);
    end
    #1 cmd_valid = 1'b0;
    check("cmd_handshake", 32'(hs), 32'd1);
  endtask

  task automatic send_payload(input int nbytes, input int seed);
    bit hs;
    int n;
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      s_axis_tdata  = pat(seed, i);
      s_axis_tlast  = (i == nbytes - 1);
      s_axis_tvalid = 1'b1;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 2000) begin
        #4;
        hs = s_axis_tready;
        @(posedge clk);
        n++;
        if (!hs) @(negedge clk);
      end
      if (!hs) begin
        check("pay_handshake", 32'(hs), 32'd1);
        break;
      end
    end
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic do_frame(input int len_req, input logic [47:0] mac,
                          input logic [31:0] ip, input logic [15:0] port,
                          input int nsent, input int seed, input bit lat);
    int flen, s0, l0, f0, k, L;
    int exp_s, exp_l;
    L     = (len_req > 1472) ? 1472 : len_req;
    exp_s = (nsent < L) ? 1 : 0;
    exp_l = ((len_req > 1472) ? 1 : 0) + ((nsent > L) ? 1 : 0);
    push_frame(len_req, mac, ip, port, nsent, seed, flen);
    s0 = short_cnt;
    l0 = long_cnt;
    f0 = frames_done;
    send_cmd(len_req, mac, ip, port);
    if (lat) begin
      k = 0;
      do begin
        @(posedge clk);
        #1;
        k++;
      end while (!m_axis_tvalid && k < 10);
      check("first_valid_latency", 32'(k), 32'd3);
    end
    if (nsent > 0) send_payload(nsent, seed);
    k = 0;
    while (frames_done == f0 && k < 8000) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    check("frame_done", 32'(frames_done > f0), 32'd1);
    check("frame_len", 32'(last_frame_len), 32'(flen));
    check("err_short_pulses", 32'(short_cnt - s0), 32'(exp_s));
    check("err_long_pulses", 32'(long_cnt - l0), 32'(exp_l));
    check("sb_drained", 32'(sb.size()), 32'd0);
    exp_id = exp_id + 16'd1;
  endtask

  initial begin
    int k;
    int flen;
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_len       = '0;
    cmd_dst_mac   = '0;
    cmd_dst_ip    = '0;
    cmd_dst_port  = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", 32'(m_axis_tdata), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_errs", 32'({err_short, err_long}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_frame(960, MAC_A, IP_A, PORT_A, 960, 1, 1'b1);
    check("f1_ip_len", 32'({cap[16], cap[17]}), 32'h03DC);
    check("f1_udp_len", 32'({cap[38], cap[39]}), 32'h03C8);
    check("f1_csum", 32'({cap[24], cap[25]}), 32'hF30E);

    do_frame(960, MAC_A, IP_A, PORT_A, 960, 1, 1'b0);
    check("f2_id", 32'({cap[18], cap[19]}), 32'h0001);
    check("f2_csum", 32'({cap[24], cap[25]}), 32'hF30D);

    do_frame(4, MAC_A, IP_A, PORT_A, 4, 2, 1'b0);
    check("f3_ip_len", 32'({cap[16], cap[17]}), 32'h0020);
    check("f3_udp_len", 32'({cap[38], cap[39]}), 32'h000C);

    do_frame(8, MAC_A, IP_A, PORT_A, 3, 3, 1'b0);
    do_frame(2, MAC_A, IP_A, PORT_A, 5, 4, 1'b0);

    tready_rand = 1'b1;
    do_frame(960, MAC_A, IP_A, PORT_A, 960, 1, 1'b0);
    tready_rand = 1'b0;

    push_frame(100, MAC_A, IP_A, PORT_A, 100, 5, flen);
    send_cmd(100, MAC_A, IP_A, PORT_A);
    k = 0;
    while (frame_bytes < 20 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("reached_hdr_byte20", 32'(frame_bytes >= 20), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_tlast", 32'(m_axis_tlast), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_id = 16'd0;

    do_frame(4, MAC_A, IP_A, PORT_A, 4, 6, 1'b0);
    check("post_rst_id", 32'({cap[18], cap[19]}), 32'h0000);

    do_frame(2000, MAC_A, IP_A, PORT_A, 1472, 7, 1'b0);
    check("clamp_ip_len", 32'({cap[16], cap[17]}), 32'h05DC);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
